// File: rtl/pcm_to_i2s.sv
// I2S transmitter: buffers one left/right PCM pair and serialises it MSB-first
// with a one-bit delay after each word-select edge and zero padding to slot end.
module pcm_to_i2s #(
  parameter int NUMBER_OF_BITS = 8,
  parameter int SLOT_BITS      = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [NUMBER_OF_BITS-1:0] in_left,
  input  logic [NUMBER_OF_BITS-1:0] in_right,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic                      ws,
  output logic                      data_out,
  output logic                      underrun
);

  localparam int CW = (SLOT_BITS > 1) ? $clog2(SLOT_BITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SLOT_BITS - 1);
  localparam logic [CW-1:0] CNT_NB   = CW'(NUMBER_OF_BITS);

  if (SLOT_BITS < NUMBER_OF_BITS + 1) begin : g_bad_slot
    $error("pcm_to_i2s: SLOT_BITS must be at least NUMBER_OF_BITS + 1");
  end

  typedef enum logic {IDLE, RUN} state_t;

  state_t                    state_q, state_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic                      ws_q, ws_d;
  logic                      data_q, data_d;
  logic                      urun_q, urun_d;
  logic [NUMBER_OF_BITS-1:0] buf_l_q, buf_l_d;
  logic [NUMBER_OF_BITS-1:0] buf_r_q, buf_r_d;
  logic                      buf_full_q, buf_full_d;
  logic [NUMBER_OF_BITS-1:0] sh_l_q, sh_l_d;
  logic [NUMBER_OF_BITS-1:0] sh_r_q, sh_r_d;
  logic                      accept;
  logic                      frame_start;

  assign in_ready = !buf_full_q;
  assign ws       = ws_q;
  assign data_out = data_q;
  assign underrun = urun_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      ws_q       <= 1'b0;
      data_q     <= 1'b0;
      urun_q     <= 1'b0;
      buf_l_q    <= '0;
      buf_r_q    <= '0;
      buf_full_q <= 1'b0;
      sh_l_q     <= '0;
      sh_r_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ws_q       <= ws_d;
      data_q     <= data_d;
      urun_q     <= urun_d;
      buf_l_q    <= buf_l_d;
      buf_r_q    <= buf_r_d;
      buf_full_q <= buf_full_d;
      sh_l_q     <= sh_l_d;
      sh_r_q     <= sh_r_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ws_d       = ws_q;
    data_d     = 1'b0;
    urun_d     = 1'b0;
    buf_l_d    = buf_l_q;
    buf_r_d    = buf_r_q;
    buf_full_d = buf_full_q;
    sh_l_d     = sh_l_q;
    sh_r_d     = sh_r_q;

    accept      = in_valid && !buf_full_q;
    frame_start = enable && ((state_q == IDLE) || (ws_q && (cnt_q == CNT_LAST)));

    if (frame_start) begin
      state_d = RUN;
      cnt_d   = '0;
      ws_d    = 1'b0;
      if (buf_full_q) begin
        sh_l_d     = buf_l_q;
        sh_r_d     = buf_r_q;
        buf_full_d = 1'b0;
      end else begin
        sh_l_d = '0;
        sh_r_d = '0;
        urun_d = 1'b1;
      end
    end else if (state_q == RUN) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d = '0;
        if (ws_q) begin
          state_d = IDLE;
          ws_d    = 1'b0;
        end else begin
          ws_d = 1'b1;
        end
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
      // Data is driven from the next slot position so the MSB lands one cycle after the ws edge.
      if ((state_d == RUN) && (cnt_d != '0) && (cnt_d <= CNT_NB)) begin
        if (ws_d) begin
          data_d = sh_r_q[NUMBER_OF_BITS-1];
          sh_r_d = sh_r_q << 1;
        end else begin
          data_d = sh_l_q[NUMBER_OF_BITS-1];
          sh_l_d = sh_l_q << 1;
        end
      end
    end

    // Accept never collides with the load at a frame start: both require opposite buffer states.
    if (accept) begin
      buf_l_d    = in_left;
      buf_r_d    = in_right;
      buf_full_d = 1'b1;
    end
  end

endmodule

// File: tb/tb_pcm_to_i2s.sv
// Bench for pcm_to_i2s: a frame-level reference model queues expected words,
// a monitor decodes the serial I2S stream and checks it against that queue.
module tb_pcm_to_i2s;
  localparam int NB = 8;
  localparam int SB = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic [NB-1:0] in_left;
  logic [NB-1:0] in_right;
  logic          in_valid;
  logic          in_ready;
  logic          ws;
  logic          data_out;
  logic          underrun;

  always #5 clk = ~clk;

  pcm_to_i2s #(.NUMBER_OF_BITS(NB), .SLOT_BITS(SB)) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .in_left  (in_left),
    .in_right (in_right),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .ws       (ws),
    .data_out (data_out),
    .underrun (underrun)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at time %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [NB-1:0] l;
    logic [NB-1:0] r;
    int            urun;
  } frame_t;

  frame_t expq[$];

  // Reference model: one buffer slot, frames of 2*SB cycles started by enable.
  bit            m_full = 0;
  bit            m_run  = 0;
  int            m_pos  = 0;
  logic [NB-1:0] m_bl, m_br;
  bit            m_ws_exp = 0;

  always @(negedge clk) begin
    bit     acc, fs;
    frame_t f;
    if (reset) begin
      m_full = 0; m_run = 0; m_pos = 0; m_ws_exp = 0;
      expq.delete();
    end else begin
      check("ws_timing", ws, m_ws_exp);
      check("in_ready", in_ready, !m_full);
      if (!m_run) begin
        check("idle_data", data_out, 0);
        check("idle_underrun", underrun, 0);
      end
      acc = in_valid && !m_full;
      fs  = enable && (!m_run || m_pos == 2*SB-1);
      if (fs) begin
        f.urun = m_full ? 0 : 1;
        f.l    = m_full ? m_bl : '0;
        f.r    = m_full ? m_br : '0;
        expq.push_back(f);
        m_full = 0; m_run = 1; m_pos = 0;
      end else if (m_run) begin
        if (m_pos == 2*SB-1) m_run = 0;
        else m_pos++;
      end
      if (acc) begin
        m_bl = in_left; m_br = in_right; m_full = 1;
      end
      m_ws_exp = m_run && (m_pos >= SB);
    end
  end

  // Monitor: the last SB data samples form one slot window, decoded on each ws edge.
  bit            hist[$];
  bit            pws = 0;
  int            urun_seen = 0;
  int            hi_len = 0;
  logic [NB-1:0] lw;
  bit            lpad;

  function automatic void decode(output logic [NB-1:0] w, output bit pad_ok);
    w = '0;
    pad_ok = (hist.size() == SB);
    if (!pad_ok) return;
    for (int j = 0; j < SB; j++) begin
      if (j >= 1 && j <= NB) w = {w[NB-2:0], hist[j]};
      else if (hist[j]) pad_ok = 0;
    end
  endfunction

  always @(negedge clk) begin
    logic [NB-1:0] rw;
    bit            rpad;
    frame_t        f;
    if (reset) begin
      hist.delete(); pws = 0; urun_seen = 0; hi_len = 0; lw = '0; lpad = 0;
    end else begin
      if (ws && !pws) begin
        decode(lw, lpad);
        hi_len = 0;
      end
      if (!ws && pws) begin
        decode(rw, rpad);
        check("ws_high_len", hi_len, SB);
        check("frame_expected", expq.size() > 0, 1);
        if (expq.size() > 0) begin
          f = expq.pop_front();
          check("left_word", lw, f.l);
          check("right_word", rw, f.r);
          check("left_pad", lpad, 1);
          check("right_pad", rpad, 1);
          check("underrun_pulses", urun_seen, f.urun);
        end
        urun_seen = 0;
      end
      if (ws) hi_len++;
      urun_seen += underrun;
      hist.push_back(data_out);
      if (hist.size() > SB) void'(hist.pop_front());
      pws = ws;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [NB-1:0] l, input logic [NB-1:0] r, input bit keep);
    bit done = 0;
    int n = 0;
    in_left = l; in_right = r; in_valid = 1'b1;
    while (!done && n < 400) begin
      @(negedge clk);
      done = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!keep) in_valid = 1'b0;
    check("push_accepted", done, 1);
  endtask

  task automatic wait_pos(input int p);
    int n = 0;
    while (!(m_run && m_pos == p) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("reached_slot_position", n < 200, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; enable = 1'b0; in_valid = 1'b0; in_left = '0; in_right = '0;
    repeat (3) @(posedge clk);
    #2;
    check("reset_ws", ws, 0);
    check("reset_data", data_out, 0);
    check("reset_underrun", underrun, 0);
    check("reset_in_ready", in_ready, 1);
    @(posedge clk);
    #1 reset = 1'b0;
    cycles(4);

    // Single frame with a pre-loaded pair.
    push(8'hA5, 8'h3C, 0);
    enable = 1'b1;
    cycles(2*SB - 4);
    enable = 1'b0;
    cycles(2*SB + 8);

    // Underrun frame, then a pair pushed mid-frame for the next one.
    enable = 1'b1;
    cycles(4);
    push(8'hFF, 8'h01, 0);
    cycles(2*SB);
    enable = 1'b0;
    cycles(2*SB + 8);

    // Back-pressure: in_valid held high across incrementing pairs.
    enable = 1'b1;
    for (int i = 0; i < 6; i++) push(NB'(i), NB'(i), 1);
    in_valid = 1'b0;
    cycles(4*SB);
    enable = 1'b0;
    cycles(2*SB + 8);

    // Disable at k=5; pair pushed afterwards must survive idle.
    push(8'h5A, 8'hC3, 0);
    enable = 1'b1;
    wait_pos(5);
    enable = 1'b0;
    push(8'h77, 8'h88, 0);
    cycles(3*SB);
    enable = 1'b1;
    cycles(2*SB + 2);
    enable = 1'b0;
    cycles(2*SB + 8);

    // Random pairs with random gaps.
    enable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if ($urandom_range(0, 3) == 0) cycles($urandom_range(1, 40));
      push(NB'($urandom), NB'($urandom), bit'($urandom_range(0, 1)));
    end
    in_valid = 1'b0;
    cycles(4*SB);

    // Reset mid-frame with a full buffer.
    push(8'h11, 8'h22, 0);
    wait_pos(SB + 3);
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check("midreset_ws", ws, 0);
    check("midreset_data", data_out, 0);
    check("midreset_underrun", underrun, 0);
    check("midreset_in_ready", in_ready, 1);
    enable = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    cycles(2*SB);
    enable = 1'b1;
    cycles(2*SB + 2);
    enable = 1'b0;
    cycles(2*SB + 8);

    check("queue_drained", expq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
